// File: rtl/pc_epc_unit.sv
// pc_epc_unit: program counter and exception PC register stage.
// Commits the selected next-PC each cycle, or runs the exception sequence:
// save PC-4 into EPC, fetch the handler byte from the vector table, load it into PC.
module pc_epc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] VEC_BASE = 32'd253,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_src_in,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic [2:0]  exc_req,
    input  logic [7:0]  exc_mem_data,
    output logic        exc_mem_rd,
    output logic [31:0] exc_mem_addr,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic        busy,
    output logic        exc_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_mem_rd;
    logic [31:0] r_mem_addr;
    logic        r_busy;
    logic        r_done;
    logic [2:0]  r_cnt;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_epc_nxt;
    logic        w_mem_rd_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic [2:0]  w_cnt_nxt;

    logic        w_cond;
    logic [1:0]  w_code;

    // Branch condition selected by branch_type from the ALU flags
    always_comb begin
        w_cond = 1'b0;
        case (branch_type)
            2'b00:   w_cond = alu_zero;
            2'b01:   w_cond = ~alu_zero;
            2'b10:   w_cond = alu_zero | ~alu_gt;
            default: w_cond = alu_gt;
        endcase
    end

    // Exception code: lowest set request bit wins
    always_comb begin
        w_code = 2'd0;
        if (exc_req[0])      w_code = 2'd0;
        else if (exc_req[1]) w_code = 2'd1;
        else                 w_code = 2'd2;
    end

    // Next-state and next-register values for the sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_mem_rd_nxt   = r_mem_rd;
        w_mem_addr_nxt = r_mem_addr;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            IDLE: begin
                if (exc_req != 3'b000) begin
                    w_epc_nxt      = r_pc - 32'd4;
                    w_mem_addr_nxt = VEC_BASE + {30'b0, w_code};
                    w_mem_rd_nxt   = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_cnt_nxt      = LAT_INIT;
                    w_state_nxt    = FETCH;
                end else if (pc_write | (pc_write_cond & w_cond)) begin
                    w_pc_nxt = pc_src_in;
                end
            end
            FETCH: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_pc_nxt     = {24'b0, exc_mem_data};
                    w_mem_rd_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = LOAD;
                end
            end
            LOAD: begin
                w_done_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Register all state and outputs; synchronous reset aborts any sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_epc      <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign exc_mem_rd   = r_mem_rd;
    assign exc_mem_addr = r_mem_addr;
    assign pc_out       = r_pc;
    assign epc_out      = r_epc;
    assign busy         = r_busy;
    assign exc_done     = r_done;

endmodule
